// File: rtl/gpr_pkg.sv
// Shared constants and types for the GPR write-port arbiter.
package gpr_pkg;

    localparam int GPR_DW    = 32;
    localparam int GPR_AW    = 5;
    localparam int GPR_NREGS = 2 ** GPR_AW;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } gpr_state_e;

endpackage

// File: rtl/gpr_wr_arb_if.sv
// Requester, register-file write port and clear-control signals of gpr_wr_arb.
interface gpr_wr_arb_if #(
    parameter int DW = gpr_pkg::GPR_DW,
    parameter int AW = gpr_pkg::GPR_AW
);

    logic          req0;
    logic          req1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] data0;
    logic [DW-1:0] data1;
    logic          clr_req;

    logic [1:0]    gnt;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          clr_done;

    modport master (
        output req0, req1, addr0, addr1, data0, data1, clr_req,
        input  gnt, wr_en, wr_addr, wr_data, busy, clr_done
    );

    modport slave (
        input  req0, req1, addr0, addr1, data0, data1, clr_req,
        output gnt, wr_en, wr_addr, wr_data, busy, clr_done
    );

endinterface

// File: rtl/gpr_wr_arb_rr_arb2.sv
// Two-way round-robin selector; ptr names the requester that wins a tie.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ptr ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/gpr_wr_arb.sv
// Arbitrates two requesters onto a register-file write port; define
// GPR_WR_ARB_CLEAR_EN to build in the sequenced register-file clear.
module gpr_wr_arb
    import gpr_pkg::*;
#(
    parameter int DW = GPR_DW,
    parameter int AW = GPR_AW
) (
    input  logic         clk,
    input  logic         rst,
    gpr_wr_arb_if.slave  bus
);

    gpr_state_e    state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic [1:0]    arb_gnt;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    logic [1:0]    gnt_q, gnt_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [DW-1:0] wr_data_q, wr_data_d;
    logic          busy_q, busy_d;
    logic          clr_done_q, clr_done_d;

`ifdef GPR_WR_ARB_CLEAR_EN
    // Next address to clear; wrapping to 0 marks the clr_done cycle.
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

    rr_arb2 u_rr_arb2 (
        .req ({bus.req1, bus.req0}),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt)
    );

    assign sel_addr = arb_gnt[0] ? bus.addr0 : bus.addr1;
    assign sel_data = arb_gnt[0] ? bus.data0 : bus.data1;

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = 2'b00;
        wr_en_d    = 1'b0;
        wr_addr_d  = '0;
        wr_data_d  = '0;
        busy_d     = 1'b0;
        clr_done_d = 1'b0;
`ifdef GPR_WR_ARB_CLEAR_EN
        clr_cnt_d  = clr_cnt_q;
`endif

        case (state_q)
            IDLE: begin
`ifdef GPR_WR_ARB_CLEAR_EN
                if (bus.clr_req) begin
                    state_d   = CLEAR;
                    wr_en_d   = 1'b1;
                    wr_addr_d = AW'(1);
                    busy_d    = 1'b1;
                    clr_cnt_d = AW'(2);
                end else
`endif
                if (arb_gnt != 2'b00) begin
                    gnt_d    = arb_gnt;
                    // Priority passes to the requester that did not just win.
                    rr_ptr_d = arb_gnt[0];
                    if (sel_addr != '0) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_data;
                    end
                end
            end
`ifdef GPR_WR_ARB_CLEAR_EN
            CLEAR: begin
                if (clr_cnt_q != '0) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = clr_cnt_q;
                    busy_d    = 1'b1;
                    clr_cnt_d = clr_cnt_q + AW'(1);
                end else begin
                    clr_done_d = 1'b1;
                    state_d    = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= 1'b0;
            gnt_q      <= 2'b00;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            clr_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            clr_done_q <= clr_done_d;
        end
    end

`ifdef GPR_WR_ARB_CLEAR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt_q <= '0;
        end else begin
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.clr_done = clr_done_q;
`else
    assign bus.busy     = 1'b0;
    assign bus.clr_done = 1'b0;
`endif

    assign bus.gnt     = gnt_q;
    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule

// File: tb/tb_gpr_wr_arb.sv
// Directed and randomized bench for gpr_wr_arb, checked against a queue-based
// reference model; follows GPR_WR_ARB_CLEAR_EN to know whether clearing exists.
module tb_gpr_wr_arb;
    import gpr_pkg::*;

    localparam int DW    = GPR_DW;
    localparam int AW    = GPR_AW;
    localparam int NREGS = GPR_NREGS;

`ifdef GPR_WR_ARB_CLEAR_EN
    localparam bit CLEAR_EN = 1'b1;
`else
    localparam bit CLEAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [1:0]    gnt;
        logic          wr_en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          busy;
        logic          done;
    } out_t;

    logic clk;
    logic rst;

    gpr_wr_arb_if #(.DW(DW), .AW(AW)) bus ();

    gpr_wr_arb #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_assert;
    int   n_fail;
    out_t exp_q[$];
    int   last_winner;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic check_outputs(input string tag, input out_t e);
        check({tag, ".gnt"},      64'(bus.gnt),      64'(e.gnt));
        check({tag, ".wr_en"},    64'(bus.wr_en),    64'(e.wr_en));
        check({tag, ".wr_addr"},  64'(bus.wr_addr),  64'(e.addr));
        check({tag, ".wr_data"},  64'(bus.wr_data),  64'(e.data));
        check({tag, ".busy"},     64'(bus.busy),     64'(e.busy));
        check({tag, ".clr_done"}, 64'(bus.clr_done), 64'(e.done));
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_winner = 1;
    endtask

    // Expected outputs for the cycle after the coming edge, from the current inputs.
    task automatic model_next(output out_t e);
        out_t          w;
        int            win;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        e = '0;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end else if (CLEAR_EN && bus.clr_req) begin
            for (int r = 1; r < NREGS; r++) begin
                w       = '0;
                w.wr_en = 1'b1;
                w.addr  = AW'(r);
                w.busy  = 1'b1;
                exp_q.push_back(w);
            end
            w      = '0;
            w.done = 1'b1;
            exp_q.push_back(w);
            e = exp_q.pop_front();
        end else if (bus.req0 || bus.req1) begin
            if (bus.req0 && bus.req1) win = 1 - last_winner;
            else                      win = bus.req0 ? 0 : 1;
            last_winner = win;
            e.gnt = (win == 0) ? 2'b01 : 2'b10;
            a = (win == 0) ? bus.addr0 : bus.addr1;
            d = (win == 0) ? bus.data0 : bus.data1;
            if (a != '0) begin
                e.wr_en = 1'b1;
                e.addr  = a;
                e.data  = d;
            end
        end
    endtask

    task automatic step(input string tag, output out_t e);
        model_next(e);
        @(posedge clk);
        #1;
        check_outputs(tag, e);
    endtask

    task automatic drive(input logic r0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic r1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic clr);
        bus.req0 = r0; bus.addr0 = a0; bus.data0 = d0;
        bus.req1 = r1; bus.addr1 = a1; bus.data1 = d1;
        bus.clr_req = clr;
    endtask

    // Raise rst away from any edge and confirm outputs drop without waiting for the clock.
    task automatic pulse_reset(input string tag);
        rst = 1'b1;
        #1;
        check_outputs({tag, "_async"}, '0);
        model_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs({tag, "_hold"}, '0);
        end
        rst = 1'b0;
    endtask

    initial begin
        out_t e;
        int   n_writes;
        int   n_done;
        bit   p0, p1;

        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b0;
        model_reset();
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        #3;
        pulse_reset("reset");

        // Both requesters held high straight after reset alternate, starting with 0.
        drive(1'b1, AW'(7), 32'h0000_0011, 1'b1, AW'(9), 32'h0000_0022, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step($sformatf("rr%0d", i), e);
            check($sformatf("rr_seq%0d", i), 64'(bus.gnt), (i % 2 == 0) ? 64'd1 : 64'd2);
        end
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        step("idle0", e);

        drive(1'b1, AW'(3), 32'h0000_00A5, 1'b0, '0, '0, 1'b0);
        step("single0", e);
        check("single0_addr", 64'(bus.wr_addr), 64'd3);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        step("idle1", e);

        drive(1'b0, '0, '0, 1'b1, '0, 32'hFFFF_FFFF, 1'b0);
        step("addr0", e);
        check("addr0_gnt", 64'(bus.gnt), 64'd2);
        check("addr0_wr_en", 64'(bus.wr_en), 64'd0);
        drive(1'b1, AW'(4), 32'h0000_0055, 1'b0, '0, '0, 1'b1);
        step("clr_start", e);
        n_writes = (bus.wr_en && bus.busy) ? 1 : 0;
        n_done   = 0;
        bus.clr_req = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 5) bus.clr_req = 1'b1;
            if (i == 6) bus.clr_req = 1'b0;
            step($sformatf("clr%0d", i), e);
            if (bus.wr_en && bus.busy) n_writes++;
            if (bus.clr_done) n_done++;
            if (e.gnt[0]) bus.req0 = 1'b0;
        end
        check("clr_write_count", 64'(n_writes), CLEAR_EN ? 64'(NREGS - 1) : 64'd0);
        check("clr_done_count", 64'(n_done), CLEAR_EN ? 64'd1 : 64'd0);

        p0 = 1'b0;
        p1 = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!p0 && $urandom_range(9) < 6) begin
                p0 = 1'b1;
                bus.addr0 = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
                bus.data0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(9) < 6) begin
                p1 = 1'b1;
                bus.addr1 = ($urandom_range(7) == 0) ? '0 : AW'($urandom);
                bus.data1 = DW'($urandom);
            end
            bus.req0    = p0;
            bus.req1    = p1;
            bus.clr_req = ($urandom_range(59) == 0);
            step($sformatf("rnd%0d", c), e);
            if (e.gnt[0]) p0 = 1'b0;
            if (e.gnt[1]) p1 = 1'b0;
        end

        // Reset in the middle of a clear: no clr_done, no resume afterwards.
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        pulse_reset("pre_abort");
        bus.clr_req = 1'b1;
        step("abort_start", e);
        bus.clr_req = 1'b0;
        for (int i = 0; i < 9; i++) step($sformatf("abort_run%0d", i), e);
        check("abort_addr", 64'(bus.wr_addr), CLEAR_EN ? 64'd10 : 64'd0);
        #2;
        pulse_reset("abort");
        for (int i = 0; i < 3; i++) step($sformatf("after_abort%0d", i), e);
        drive(1'b0, '0, '0, 1'b1, AW'(5), 32'h1234_5678, 1'b0);
        step("post_reset_req1", e);
        check("post_reset_gnt", 64'(bus.gnt), 64'd2);
        drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
        step("final_idle", e);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/gpr_wr_arb.md
GPR_WR_ARB -- requirements
Module: gpr_wr_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DW, default 32, SHALL set the data width.
REQ-003 Parameter AW, default 5, SHALL set the register address width (2**AW registers).
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, SHALL be the asynchronous active-high reset.
REQ-006 Ports req0/req1, input, 1 each, SHALL be the write requests from requesters 0 and 1.
REQ-007 Ports addr0/addr1, input, AW each, SHALL be the requested destination registers.
REQ-008 Ports data0/data1, input, DW each, SHALL be the requested write data.
REQ-009 Port clr_req, input, 1, SHALL be the level request to zero the register file.
REQ-010 Port gnt, output, 2, SHALL be the one-hot grant pulse; bit i acknowledges requester i.
REQ-011 Ports wr_en (1), wr_addr (AW), wr_data (DW), outputs, SHALL form the register-file write port.
REQ-012 Port busy, output, 1, SHALL be high while the clear sequence runs.
REQ-013 Port clr_done, output, 1, SHALL pulse for one cycle when the clear sequence ends.

Function
REQ-014 The FSM SHALL have states IDLE and CLEAR.
REQ-015 In IDLE, requester i SHALL hold req/addr/data stable until it samples gnt[i]=1.
REQ-016 All outputs SHALL be registered, and gnt SHALL assert in the same cycle as its wr_en/wr_addr/wr_data (1-cycle latency from the sampled req).
REQ-017 At most one grant SHALL issue per cycle.
REQ-018 When a single request is pending, it SHALL be granted; back-to-back grants to the same requester SHALL be allowed every cycle.
REQ-019 When both requests are pending, the requester not granted last SHALL win (round-robin); after reset, requester 0 SHALL win.
REQ-020 A request with addr=0 SHALL be granted, but wr_en SHALL stay 0 (register 0 is hardwired zero).
REQ-021 When clr_req=1 in IDLE, it SHALL take priority over both requests: no grant that cycle, and the FSM SHALL move to CLEAR.
REQ-022 In CLEAR, the block SHALL write 0 to addresses 1..2**AW-1, one per cycle ascending, with wr_en=1 and busy=1, and SHALL issue no grants.
REQ-023 After the write to the last address, the FSM SHALL return to IDLE, and clr_done SHALL be 1 for exactly the following cycle.
REQ-024 A clr_req asserted while in CLEAR SHALL be ignored, and SHALL not restart or extend the sequence.
REQ-025 Pending requests during CLEAR SHALL wait; round-robin SHALL resume from the pointer held before CLEAR.
REQ-026 When wr_en=0, wr_addr and wr_data SHALL hold 0.

Reset
REQ-027 rst SHALL immediately force gnt=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, clr_done=0, state=IDLE, and round-robin pointer=requester 0.
REQ-028 A reset during CLEAR SHALL abort the sequence without clr_done, and no resume SHALL occur after reset release.

Configuration
REQ-029 Macro GPR_WR_ARB_CLEAR_EN SHALL compile in the CLEAR state, clr_req handling, and the clear address counter.
REQ-030 Without GPR_WR_ARB_CLEAR_EN, the clr_req, busy and clr_done ports SHALL remain present; clr_req SHALL be ignored, and busy and clr_done SHALL be tied 0.

Structure
REQ-031 Package gpr_pkg SHALL hold DW and AW defaults, the register count constant, and the FSM state typedef.
REQ-032 Round-robin selection SHALL be in sub-module rr_arb2 (inputs req[1:0] and last pointer; output one-hot grant).

Verification
REQ-033 Scenario: req0=1, addr0=3, data0=0x0000_00A5 alone -> next cycle gnt=01, wr_en=1, wr_addr=3, wr_data=0x0000_00A5.
REQ-034 Scenario: req0 and req1 held high for 4 cycles after reset -> gnt sequence 01,10,01,10.
REQ-035 Scenario: req1=1, addr1=0, data1=0xFFFF_FFFF -> gnt=10, wr_en=0, wr_addr=0, wr_data=0.
REQ-036 Scenario: clr_req pulsed with req0 pending -> 31 cycles of wr_en=1 with addresses 1..31 and data 0, busy=1, then clr_done=1 for 1 cycle, then gnt=01.
REQ-037 Scenario: rst asserted at address 10 of a clear -> all outputs 0 asynchronously; no clr_done; after release, req1 alone -> gnt=10.
